// File: rtl/game_pkg.sv
// Shared game-calc constants: index-width helper, default box sizes and the
// level-1 star layout.
package game_pkg;

    function automatic int ITEM_IDX_W(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    localparam int DEF_ITEM_W = 12;
    localparam int DEF_CHAR_W = 12;

    // Item i lives at bits [10*i +: 10], so item 0 is the rightmost field.
    localparam int L1_N_ITEMS = 4;
    localparam logic [10*L1_N_ITEMS-1:0] L1_POS_X = {10'd300, 10'd200, 10'd100, 10'd912};
    localparam logic [10*L1_N_ITEMS-1:0] L1_POS_Y = {10'd50, 10'd50, 10'd50, 10'd326};

endpackage

// File: rtl/item_hit_cmp.sv
// Square bounding-box overlap test between box a and box b, inclusive bounds,
// evaluated 11 bits wide so right/bottom edges never wrap.
module item_hit_cmp (
    input  logic [9:0] ax,
    input  logic [9:0] ay,
    input  logic [9:0] aw,
    input  logic [9:0] bx,
    input  logic [9:0] by,
    input  logic [9:0] bw,
    output logic       hit
);

    logic x_ovl;
    logic y_ovl;

    assign x_ovl = ({1'b0, ax} <= ({1'b0, bx} + {1'b0, bw})) &&
                   (({1'b0, ax} + {1'b0, aw}) >= {1'b0, bx});
    assign y_ovl = ({1'b0, ay} <= ({1'b0, by} + {1'b0, bw})) &&
                   (({1'b0, ay} + {1'b0, aw}) >= {1'b0, by});
    assign hit   = x_ovl && y_ovl;

endmodule

// File: rtl/collectible_bank.sv
// Bank of static collectibles: round-robin overlap scan, collected-state
// latch, touch pulse, saturating score and optional timed respawn.
module collectible_bank
    import game_pkg::*;
#(
    parameter int N_ITEMS = 8,
    parameter int ITEM_W = DEF_ITEM_W,
    parameter int CHAR_W = DEF_CHAR_W,
    parameter logic [10*N_ITEMS-1:0] POS_X = {N_ITEMS{10'd0}},
    parameter logic [10*N_ITEMS-1:0] POS_Y = {N_ITEMS{10'd0}},
    parameter int SCORE_W = 8,
    parameter int RESPAWN = 0,
    parameter int RESPAWN_CYCLES = 1000,
    localparam int IW = ITEM_IDX_W(N_ITEMS)
) (
    input  logic               sys_clk,
    input  logic               RST_N,
    input  logic               restart,
    input  logic [9:0]         char_X,
    input  logic [9:0]         char_Y,
    input  logic [9:0]         bg_pos,
    input  logic [IW-1:0]      rd_idx,
    output logic [9:0]         item_x,
    output logic [9:0]         item_y,
    output logic               item_en,
    output logic [N_ITEMS-1:0] en_mask,
    output logic               touch,
    output logic [IW-1:0]      touch_idx,
    output logic [SCORE_W-1:0] score,
    output logic               all_collected
);

    logic [IW-1:0]      scan_idx;
    logic [N_ITEMS-1:0] scan_sel;
    logic [9:0]         scan_x;
    logic [9:0]         scan_y;
    logic               scan_en;
    logic               scan_hit;
    logic               collect;
    logic [N_ITEMS-1:0] collect_vec;
    logic [N_ITEMS-1:0] respawn_set;

    always_comb begin
        scan_sel = '0;
        scan_x   = '0;
        scan_y   = '0;
        scan_en  = 1'b0;
        for (int i = 0; i < N_ITEMS; i++) begin
            if (scan_idx == IW'(i)) begin
                scan_sel[i] = 1'b1;
                scan_x      = POS_X[10*i +: 10];
                scan_y      = POS_Y[10*i +: 10];
                scan_en     = en_mask[i];
            end
        end
    end

    item_hit_cmp u_hit (
        .ax  (char_X),
        .ay  (char_Y),
        .aw  (10'(CHAR_W)),
        .bx  (scan_x),
        .by  (scan_y),
        .bw  (10'(ITEM_W)),
        .hit (scan_hit)
    );

    // Restart suppresses any collection evaluated in the same cycle.
    assign collect     = scan_en && scan_hit && !restart;
    assign collect_vec = scan_sel & {N_ITEMS{collect}};

    always_ff @(posedge sys_clk or negedge RST_N) begin
        if (!RST_N) begin
            scan_idx  <= '0;
            en_mask   <= '1;
            touch     <= 1'b0;
            touch_idx <= '0;
            score     <= '0;
        end else if (restart) begin
            scan_idx  <= '0;
            en_mask   <= '1;
            touch     <= 1'b0;
            touch_idx <= '0;
            score     <= '0;
        end else begin
            scan_idx <= (int'(scan_idx) == N_ITEMS - 1) ? '0 : scan_idx + 1'b1;
            touch    <= collect;
            en_mask  <= (en_mask | respawn_set) & ~collect_vec;
            if (collect) begin
                touch_idx <= scan_idx;
            end
            if (collect && (score != '1)) begin
                score <= score + 1'b1;
            end
        end
    end

    generate
        if (RESPAWN != 0) begin : g_respawn
            localparam int RCW = $clog2(RESPAWN_CYCLES + 1);
            for (genvar g = 0; g < N_ITEMS; g++) begin : g_item
                logic [RCW-1:0] rsp_cnt;
                always_ff @(posedge sys_clk or negedge RST_N) begin
                    if (!RST_N) begin
                        rsp_cnt <= '0;
                    end else if (restart) begin
                        rsp_cnt <= '0;
                    end else if (collect_vec[g]) begin
                        rsp_cnt <= RCW'(RESPAWN_CYCLES);
                    end else if (rsp_cnt != '0) begin
                        rsp_cnt <= rsp_cnt - 1'b1;
                    end
                end
                // Terminal count: the 1 -> 0 step re-enables the item.
                assign respawn_set[g] = (rsp_cnt == RCW'(1));
            end
        end else begin : g_no_respawn
            assign respawn_set = '0;
        end
    endgenerate

    always_comb begin
        item_x  = '0;
        item_y  = '0;
        item_en = 1'b0;
        for (int i = 0; i < N_ITEMS; i++) begin
            if (rd_idx == IW'(i)) begin
                item_x  = POS_X[10*i +: 10] - bg_pos;
                item_y  = POS_Y[10*i +: 10];
                item_en = en_mask[i];
            end
        end
    end

    assign all_collected = (en_mask == '0);

endmodule

// File: doc/collectible_bank.md
# collectible_bank

Parametrised bank of N static collectibles (stars/coins) at fixed world coordinates, replacing one-module-per-star instances. Checks character overlap against one item per clock (round-robin scan) and latches each item's collected state. Emits a one-cycle touch pulse with the item index and keeps a saturating score. Optional timed respawn. Sits between the character-position logic and the renderer/score display in the game-calc layer.

## Interface
- N_ITEMS, 8: number of collectibles, 1..32
- ITEM_W, 12: item box size in pixels, square
- CHAR_W, 12: character box size in pixels, square
- POS_X, {N_ITEMS{10'd0}}: packed world X per item, item i at [10*i +: 10]
- POS_Y, {N_ITEMS{10'd0}}: packed world Y per item, same packing
- SCORE_W, 8: score counter width
- RESPAWN, 0: 1 = collected items re-enable after RESPAWN_CYCLES
- RESPAWN_CYCLES, 1000: respawn delay in sys_clk cycles, ≥1
- sys_clk  in  1  clock
- RST_N  in  1  reset, asynchronous, active-low
- restart  in  1  synchronous level-restart: re-enable all, clear score
- char_X  in  10  character world X, top-left
- char_Y  in  10  character Y, top-left
- bg_pos  in  10  horizontal scroll offset
- rd_idx  in  $clog2(N_ITEMS) (min 1)  renderer item select
- item_x  out  10  screen X of item rd_idx = POS_X[rd_idx] − bg_pos, mod 2^10
- item_y  out  10  Y of item rd_idx
- item_en  out  1  item rd_idx is not collected
- en_mask  out  N_ITEMS  per-item enable bitmap
- touch  out  1  one-cycle pulse on collection
- touch_idx  out  $clog2(N_ITEMS)  index of collected item, valid with touch
- score  out  SCORE_W  collected count, saturating
- all_collected  out  1  en_mask == 0

## Operation
- Reset: en_mask all ones, scan_idx 0, touch 0, touch_idx 0, score 0, respawn counters 0; all_collected 0.
- Hit test for item i (combinational): X overlap = char_X ≤ POS_X[i]+ITEM_W and char_X+CHAR_W ≥ POS_X[i]; Y likewise. Sums computed 11 bits wide, no wraparound. Both bounds inclusive.
- Each cycle: evaluate item scan_idx. If en_mask[scan_idx] and hit: clear en_mask[scan_idx], assert touch next cycle with touch_idx = scan_idx, score += 1 unless at 2^SCORE_W−1. Disabled items never hit.
- scan_idx increments every cycle, wraps N_ITEMS−1 → 0.
- RESPAWN=1: on collection load item counter with RESPAWN_CYCLES; decrement each cycle while nonzero; on 1→0 set en_mask bit. Score not reduced. RESPAWN=0: counters not generated.
- restart: en_mask all ones, score 0, scan_idx 0, counters 0, touch 0 next cycle. Restart wins over a simultaneous hit (no pulse, no score).
- Respawn completion and hit on same item same cycle: impossible (item disabled during evaluation); respawned item eligible from next scan.
- Read port item_x/item_y/item_en purely combinational from rd_idx; rd_idx ≥ N_ITEMS returns x=0, y=0, en=0.

## Timing
- touch: registered, high exactly one cycle, the cycle after the evaluating edge; en_mask and score update on the same edge touch rises.
- Detection latency after overlap begins: 1..N_ITEMS cycles; character must overlap ≥ N_ITEMS cycles to guarantee collection (one frame ≫ N).
- At most one collection per cycle; back-to-back touches on consecutive cycles allowed for adjacent indices.
- Async reset mid-operation clears all state immediately, including a pulse in flight.

## Structure
- Package game_pkg: ITEM_IDX_W function ($clog2 with min 1), default box sizes, star coordinate constants for level 1 (POS_X/POS_Y vectors).
- Sub-module item_hit_cmp: combinational box-overlap comparator (ax, ay, aw, bx, by, bw → hit), reused by enemy/block collision later.

## Test plan
- N=4, items at (912,326),(100,50),(200,50),(300,50); char at (905,320) held 8 cycles -> single touch, touch_idx=0, score=1, en_mask=4'b1110.
- Char at (912+13,326) (one pixel beyond ITEM_W+... edge, char_X = POS_X+ITEM_W+1) -> no touch; at POS_X+ITEM_W -> touch (inclusive bound).
- Char parked on item 1 for 100 cycles -> exactly one touch; score stays 1.
- SCORE_W=2, collect 4 items -> score 1,2,3,3; all_collected=1 after fourth.
- RESPAWN=1, RESPAWN_CYCLES=10, collect item 2, move away -> en_mask[2] returns 1 exactly 10 cycles after touch edge; recollect -> score 2.
- restart asserted in the cycle item 3 is scanned with overlap -> no touch, score 0, en_mask all ones; RST_N pulsed mid-respawn -> all items enabled immediately.
